// File: rtl/em_elastic_buffer.sv
// One-cycle elastic FIFO between Execute and Memory: a circular buffer of DEPTH
// entries holding one instruction's payload, with a registered head and no in-to-out bypass.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 3
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module em_elastic_buffer #(
  parameter int WORD_SIZE       = `WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
  parameter int DEPTH           = 2,
  localparam int CNT_W          = $clog2(DEPTH + 1),
  localparam int PTR_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
  input  logic [WORD_SIZE-1:0]       pc,
  input  logic [2:0]                 funct3,
  input  logic [WORD_SIZE-1:0]       alu_result,
  input  logic [WORD_SIZE-1:0]       s2,
  input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_TYPE_SZ-1:0]   instruction_type_out,
  output logic [WORD_SIZE-1:0]       pc_out,
  output logic [2:0]                 funct3_out,
  output logic [WORD_SIZE-1:0]       alu_result_out,
  output logic [WORD_SIZE-1:0]       s2_out,
  output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
  output logic [CNT_W-1:0]           count
);

  typedef struct packed {
    logic [INSTR_TYPE_SZ-1:0]   itype;
    logic [WORD_SIZE-1:0]       pc;
    logic [2:0]                 funct3;
    logic [WORD_SIZE-1:0]       alu;
    logic [WORD_SIZE-1:0]       s2;
    logic [ROB_ENTRY_WIDTH-1:0] rob;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  entry_t           mem [DEPTH];
  entry_t           in_ent, head_ent;
  logic [PTR_W-1:0] head, tail;
  logic             push, pop;

  assign in_ent = '{itype: instruction_type, pc: pc, funct3: funct3,
                    alu: alu_result, s2: s2, rob: rob_id};

  // A full buffer still takes a new entry when the head leaves in the same cycle.
  assign in_ready  = (count < FULL) || out_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= nxt(tail);
      if (pop)  head <= nxt(head);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Payload storage is never reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[tail] <= in_ent;
  end

  // Gating on out_valid keeps the outputs at zero until something is stored.
  assign head_ent = out_valid ? mem[head] : '0;

  assign instruction_type_out = head_ent.itype;
  assign pc_out               = head_ent.pc;
  assign funct3_out           = head_ent.funct3;
  assign alu_result_out       = head_ent.alu;
  assign s2_out               = head_ent.s2;
  assign rob_id_out           = head_ent.rob;

endmodule

// File: tb/tb_em_elastic_buffer.sv
// Scoreboard bench for em_elastic_buffer: a DEPTH=2 and a DEPTH=3 instance, directed
// vectors push expected entries on accepted handshakes, a monitor checks every head.
`timescale 1ns/1ps
module tb_em_elastic_buffer;

  typedef struct packed {
    logic [2:0]  itype;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] s2;
    logic [4:0]  rob;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cur_d = 0;
  ent_t q0[$];
  ent_t q1[$];

  logic rs0 = 1'b1, fl0 = 1'b0, iv0 = 1'b0, ordy0 = 1'b0;
  logic rs1 = 1'b1, fl1 = 1'b0, iv1 = 1'b0, ordy1 = 1'b0;
  ent_t in0 = '0, in1 = '0;
  logic irdy0, ov0, irdy1, ov1;
  logic [2:0] it_o0, f3_o0, it_o1, f3_o1;
  logic [31:0] pc_o0, alu_o0, s2_o0, pc_o1, alu_o1, s2_o1;
  logic [4:0] rob_o0, rob_o1;
  logic [1:0] cnt0, cnt1;
  ent_t act0, act1;

  assign act0 = {it_o0, pc_o0, f3_o0, alu_o0, s2_o0, rob_o0};
  assign act1 = {it_o1, pc_o1, f3_o1, alu_o1, s2_o1, rob_o1};

  em_elastic_buffer #(.WORD_SIZE(32), .INSTR_TYPE_SZ(3), .ROB_ENTRY_WIDTH(5), .DEPTH(2)) u_d2 (
    .clk(clk), .reset(rs0), .flush(fl0), .in_valid(iv0), .in_ready(irdy0),
    .instruction_type(in0.itype), .pc(in0.pc), .funct3(in0.f3), .alu_result(in0.alu),
    .s2(in0.s2), .rob_id(in0.rob), .out_valid(ov0), .out_ready(ordy0),
    .instruction_type_out(it_o0), .pc_out(pc_o0), .funct3_out(f3_o0),
    .alu_result_out(alu_o0), .s2_out(s2_o0), .rob_id_out(rob_o0), .count(cnt0));

  em_elastic_buffer #(.WORD_SIZE(32), .INSTR_TYPE_SZ(3), .ROB_ENTRY_WIDTH(5), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(rs1), .flush(fl1), .in_valid(iv1), .in_ready(irdy1),
    .instruction_type(in1.itype), .pc(in1.pc), .funct3(in1.f3), .alu_result(in1.alu),
    .s2(in1.s2), .rob_id(in1.rob), .out_valid(ov1), .out_ready(ordy1),
    .instruction_type_out(it_o1), .pc_out(pc_o1), .funct3_out(f3_o1),
    .alu_result_out(alu_o1), .s2_out(s2_o1), .rob_id_out(rob_o1), .count(cnt1));

  // Side fields are derived from pc/rob so every payload bit is exercised.
  function automatic ent_t mk(input logic [31:0] p, input logic [4:0] r);
    ent_t e;
    e.itype = r[2:0];
    e.pc    = p;
    e.f3    = ~r[2:0];
    e.alu   = p ^ 32'hA5A5_0000;
    e.s2    = p + 32'd1;
    e.rob   = r;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [31:0] p, input logic [4:0] r,
                       input bit ordy, input bit fl, input bit rs);
    cur_d = d;
    if (d == 0) begin
      iv0 = v; in0 = mk(p, r); ordy0 = ordy; fl0 = fl; rs0 = rs;
      iv1 = 1'b0; ordy1 = 1'b0; fl1 = 1'b0; rs1 = 1'b0;
    end else begin
      iv1 = v; in1 = mk(p, r); ordy1 = ordy; fl1 = fl; rs1 = rs;
      iv0 = 1'b0; ordy0 = 1'b0; fl0 = 1'b0; rs0 = 1'b0;
    end
  endtask

  // One clock: record the accepted entry (or the discard) then advance past the edge.
  task automatic step();
    @(negedge clk);
    if (cur_d == 0) begin
      if (rs0 || fl0) q0.delete();
      else if (iv0 && irdy0) q0.push_back(in0);
    end else begin
      if (rs1 || fl1) q1.delete();
      else if (iv1 && irdy1) q1.push_back(in1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int d, input bit v, input logic [31:0] p, input logic [4:0] r,
                     input bit ordy, input bit fl, input bit rs);
    drive(d, v, p, r, ordy, fl, rs);
    step();
  endtask

  task automatic mon(input int d, input bit ov, input bit ordy, input ent_t act);
    ent_t e;
    int sz;
    if (!ov) return;
    sz = (d == 0) ? q0.size() : q1.size();
    checks++;
    if (sz == 0) begin
      failures++;
      $display("FAIL head%0d_unexpected: got pc 0x%0h rob %0d with nothing expected", d, act.pc, act.rob);
      return;
    end
    e = (d == 0) ? q0[0] : q1[0];
    if (act !== e) begin
      failures++;
      $display("FAIL head%0d: got pc 0x%0h rob %0d expected pc 0x%0h rob %0d (full 0x%0h vs 0x%0h)",
               d, act.pc, act.rob, e.pc, e.rob, act, e);
    end
    if (ordy) begin
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (!rs0 && !fl0) mon(0, ov0, ordy0, act0);
    if (!rs1 && !fl1) mon(1, ov1, ordy1, act1);
  end

  initial begin
    // Reset state, DEPTH=2
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_out_valid", 32'(ov0), 0);
    chk("rst_in_ready", 32'(irdy0), 1);
    chk("rst_pc_out", pc_o0, 0);

    // Streaming with out_ready high: count stays 1
    cyc(0, 1, 32'h100, 1, 1, 0, 0); chk("stream_cnt_a", 32'(cnt0), 1);
    cyc(0, 1, 32'h104, 2, 1, 0, 0); chk("stream_cnt_b", 32'(cnt0), 1);
    cyc(0, 1, 32'h108, 3, 1, 0, 0); chk("stream_cnt_c", 32'(cnt0), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);       chk("stream_drain", 32'(cnt0), 0);

    // Backpressure: fill, third held upstream, then push+pop while full
    cyc(0, 1, 32'h200, 4, 0, 0, 0); chk("bp_cnt1", 32'(cnt0), 1);
    cyc(0, 1, 32'h204, 5, 0, 0, 0); chk("bp_cnt2", 32'(cnt0), 2);
    drive(0, 1, 32'h208, 6, 0, 0, 0); #1; chk("bp_full_rdy", 32'(irdy0), 0);
    step();                          chk("bp_held_cnt", 32'(cnt0), 2);
    cyc(0, 1, 32'h208, 6, 0, 0, 0);
    drive(0, 1, 32'h208, 6, 1, 0, 0); #1; chk("full_pushpop_rdy", 32'(irdy0), 1);
    step();                          chk("full_pushpop_cnt", 32'(cnt0), 2);
    cyc(0, 0, 0, 0, 1, 0, 0);       chk("bp_drain1", 32'(cnt0), 1);
    cyc(0, 0, 0, 0, 1, 0, 0);       chk("bp_drain0", 32'(cnt0), 0);

    // Flush with an incoming entry and out_ready high: nothing survives
    cyc(0, 1, 32'h300, 10, 0, 0, 0);
    cyc(0, 1, 32'h304, 11, 0, 0, 0);
    cyc(0, 1, 32'h308, 12, 1, 1, 0);
    chk("flush_cnt", 32'(cnt0), 0);
    chk("flush_ov", 32'(ov0), 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h30C, 13, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);       chk("post_flush_cnt", 32'(cnt0), 0);

    // Mid-stream reset: held entries vanish, next push emerges alone
    cyc(0, 1, 32'h400, 20, 0, 0, 0);
    cyc(0, 1, 32'h404, 21, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0); #1;
    chk("mrst_cnt", 32'(cnt0), 0);
    chk("mrst_ov", 32'(ov0), 0);
    chk("mrst_rdy", 32'(irdy0), 1);
    cyc(0, 1, 32'h500, 5, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);       chk("mrst_drain", 32'(cnt0), 0);

    // DEPTH=3 wrap: 0x40 lands in slot 0 while the head pops
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 32'h10, 1, 0, 0, 0);
    cyc(1, 1, 32'h20, 2, 0, 0, 0);
    cyc(1, 1, 32'h30, 3, 0, 0, 0);  chk("d3_full_cnt", 32'(cnt1), 3);
    drive(1, 1, 32'h40, 4, 0, 0, 0); #1; chk("d3_full_rdy", 32'(irdy1), 0);
    drive(1, 1, 32'h40, 4, 1, 0, 0); #1; chk("d3_pushpop_rdy", 32'(irdy1), 1);
    step();                          chk("d3_pushpop_cnt", 32'(cnt1), 3);
    chk("d3_wrap_slot0", u_d3.mem[0].pc, 32'h40);
    cyc(1, 0, 0, 0, 1, 0, 0);       chk("d3_drain2", 32'(cnt1), 2);
    cyc(1, 0, 0, 0, 1, 0, 0);       chk("d3_drain1", 32'(cnt1), 1);
    cyc(1, 0, 0, 0, 1, 0, 0);       chk("d3_drain0", 32'(cnt1), 0);
    cyc(1, 0, 0, 0, 1, 0, 0);

    chk("sb0_empty", 32'(q0.size()), 0);
    chk("sb1_empty", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
